// File: rtl/ex_pkg.sv
// Shared definitions for the RV32IM execute stage: operation codes, multiply/divide
// FSM state encoding and iteration constants.
package ex_pkg;

    localparam int          MD_ITER   = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // M ops live in 6'h20-6'h27 so that op[5:3] identifies them and op[2:0] is the unit's function.
    typedef enum logic [5:0] {
        OP_ADD    = 6'h00,
        OP_SUB    = 6'h01,
        OP_SLL    = 6'h02,
        OP_SLT    = 6'h03,
        OP_SLTU   = 6'h04,
        OP_XOR    = 6'h05,
        OP_SRL    = 6'h06,
        OP_SRA    = 6'h07,
        OP_OR     = 6'h08,
        OP_AND    = 6'h09,
        OP_LUI    = 6'h0a,
        OP_AUIPC  = 6'h0b,
        OP_JAL    = 6'h0c,
        OP_JALR   = 6'h0d,
        OP_BEQ    = 6'h10,
        OP_BNE    = 6'h11,
        OP_BLT    = 6'h12,
        OP_BGE    = 6'h13,
        OP_BLTU   = 6'h14,
        OP_BGEU   = 6'h15,
        OP_MUL    = 6'h20,
        OP_MULH   = 6'h21,
        OP_MULHSU = 6'h22,
        OP_MULHU  = 6'h23,
        OP_DIV    = 6'h24,
        OP_DIVU   = 6'h25,
        OP_REM    = 6'h26,
        OP_REMU   = 6'h27
    } ex_op_e;

    typedef logic [1:0] md_state_t;

    localparam md_state_t MD_IDLE = 2'd0;
    localparam md_state_t MD_BUSY = 2'd1;
    localparam md_state_t MD_DONE = 2'd2;

    function automatic logic is_m_op(input logic [5:0] op);
        return op[5:3] == 3'b100;
    endfunction

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op >= 6'h10) && (op <= 6'h15);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand magnitudes,
// with the sign applied to the finished 64-bit accumulator.
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = MD_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    md_state_t         state;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [2:0]        func_q;
    logic              neg_main;
    logic              neg_rem;

    logic            is_div;
    logic            sign_a;
    logic            sign_b;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (func)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            3'd2:    sign_a = 1'b1;
            default: ;
        endcase
    end

    assign is_div   = func[2];
    assign a_neg    = sign_a & a[XLEN-1];
    assign b_neg    = sign_b & b[XLEN-1];
    assign mag_a    = a_neg ? -a : a;
    assign mag_b    = b_neg ? -b : b;
    assign div_zero = is_div & (b == '0);
    assign div_ovf  = is_div & ~func[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);

    // One iteration of either algorithm; the high half of acc is the partial product or remainder.
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] step;

    assign add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    assign mul_step  = acc[0] ? {add_sum, acc[XLEN-1:1]}
                              : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
    assign rem_shift = acc[2*XLEN-1:XLEN-1];
    assign rem_diff  = rem_shift - {1'b0, mcand};
    assign div_step  = rem_diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign step      = func_q[2] ? div_step : mul_step;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    assign prod = neg_main ? -acc : acc;
    assign quot = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        result = '0;
        case (func_q)
            3'd0:             result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result = quot;
            default:          result = rem;
        endcase
    end

    // Special-case divides preload a finished accumulator and skip straight to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MD_IDLE;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            func_q   <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (rdy) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        func_q <= func;
                        count  <= '0;
                        if (div_zero || div_ovf) begin
                            acc      <= div_zero ? {a, DIV0_QUOT}
                                                 : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                            mcand    <= '0;
                            neg_main <= 1'b0;
                            neg_rem  <= 1'b0;
                            state    <= MD_DONE;
                        end else begin
                            acc      <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                            mcand    <= is_div ? mag_b : mag_a;
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            state    <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        count <= '0;
                        state <= MD_IDLE;
                    end else begin
                        acc <= step;
                        if (count == CW'(ITER - 1)) begin
                            count <= '0;
                            state <= MD_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: single-cycle ALU and branch resolution, an iterative
// multiply/divide unit that stalls the front end, and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MD_ITER = ex_pkg::MD_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [5:0]      ex_op,
    input  logic            ex_use_imm,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_enable,
    output logic            stall_req,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [4:0]      mem_rd,
    output logic            mem_rd_enable
);

    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_result;
    logic            br_cond;
    logic            is_m;
    logic            is_br;
    logic            is_jump;
    logic            fire;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] result;

    logic            md_start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    assign op_b    = ex_use_imm ? ex_imm : ex_rs2;
    assign shamt   = op_b[4:0];
    assign is_m    = is_m_op(ex_op);
    assign is_br   = is_branch_op(ex_op);
    assign is_jump = (ex_op == OP_JAL) || (ex_op == OP_JALR);

    always_comb begin
        alu_result = '0;
        case (ex_op)
            OP_ADD:           alu_result = ex_rs1 + op_b;
            OP_SUB:           alu_result = ex_rs1 - op_b;
            OP_SLL:           alu_result = ex_rs1 << shamt;
            OP_SLT:           alu_result = {{(XLEN-1){1'b0}}, $signed(ex_rs1) < $signed(op_b)};
            OP_SLTU:          alu_result = {{(XLEN-1){1'b0}}, ex_rs1 < op_b};
            OP_XOR:           alu_result = ex_rs1 ^ op_b;
            OP_SRL:           alu_result = ex_rs1 >> shamt;
            OP_SRA:           alu_result = $signed(ex_rs1) >>> shamt;
            OP_OR:            alu_result = ex_rs1 | op_b;
            OP_AND:           alu_result = ex_rs1 & op_b;
            OP_LUI:           alu_result = ex_imm;
            OP_AUIPC:         alu_result = ex_pc + ex_imm;
            OP_JAL, OP_JALR:  alu_result = ex_pc + XLEN'(4);
            default:          ;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (ex_op)
            OP_BEQ:  br_cond = ex_rs1 == ex_rs2;
            OP_BNE:  br_cond = ex_rs1 != ex_rs2;
            OP_BLT:  br_cond = $signed(ex_rs1) < $signed(ex_rs2);
            OP_BGE:  br_cond = $signed(ex_rs1) >= $signed(ex_rs2);
            OP_BLTU: br_cond = ex_rs1 < ex_rs2;
            OP_BGEU: br_cond = ex_rs1 >= ex_rs2;
            default: ;
        endcase
    end

    // The front end holds while an M op is in flight; the DONE cycle releases it.
    assign md_start  = ex_valid & is_m & ~flush;
    assign stall_req = ex_valid & is_m & ~flush & (md_busy | ~md_done);
    assign fire      = ex_valid & ~flush & ~stall_req;

    assign jalr_sum      = ex_rs1 + ex_imm;
    assign branch_target = (ex_op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
    assign branch_taken  = fire & (is_jump | (is_br & br_cond));

    assign result = is_m ? md_result : alu_result;

    muldiv_iter #(
        .XLEN (XLEN),
        .ITER (MD_ITER)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .flush  (flush),
        .start  (md_start),
        .func   (ex_op[2:0]),
        .a      (ex_rs1),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Every enabled edge loads the boundary; a stalled or flushed cycle becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_rd        <= '0;
            mem_rd_enable <= 1'b0;
        end else if (rdy) begin
            mem_valid     <= fire;
            mem_result    <= result;
            mem_rd        <= ex_rd;
            mem_rd_enable <= fire & ex_rd_enable & ~is_br;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus randomized ALU, branch and
// multiply/divide traffic compared against an arithmetic reference model.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic        ex_use_imm;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_enable;
    logic        stall_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic [4:0]  mem_rd;
    logic        mem_rd_enable;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage #(
        .XLEN    (32),
        .MD_ITER (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_use_imm    (ex_use_imm),
        .ex_pc         (ex_pc),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_rd_enable  (ex_rd_enable),
        .stall_req     (stall_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_rd        (mem_rd),
        .mem_rd_enable (mem_rd_enable)
    );

    ex_op_e single_ops [20] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                                OP_SRA, OP_OR, OP_AND, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    ex_op_e m_ops [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    // Reference model: instruction semantics written directly with 64-bit and integer arithmetic.
    function automatic logic [31:0] refResult(input ex_op_e op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] pc,
                                              input logic [31:0] imm);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      ub;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (op)
            OP_ADD:          return a + b;
            OP_SUB:          return a - b;
            OP_SLL:          return a << (b % 32);
            OP_SLT:          return (ia < ib) ? 32'd1 : 32'd0;
            OP_SLTU:         return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:          return a ^ b;
            OP_SRL:          return a >> (b % 32);
            OP_SRA:          return 32'(ia >>> (b % 32));
            OP_OR:           return a | b;
            OP_AND:          return a & b;
            OP_LUI:          return imm;
            OP_AUIPC:        return pc + imm;
            OP_JAL, OP_JALR: return pc + 32'd4;
            OP_MUL:    begin p = 64'(sa * sb);                        return p[31:0];  end
            OP_MULH:   begin p = 64'(sa * sb);                        return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub);                        return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 32'd0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic refTaken(input ex_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_JAL, OP_JALR: return 1'b1;
            OP_BEQ:          return a == b;
            OP_BNE:          return a != b;
            OP_BLT:          return int'(a) < int'(b);
            OP_BGE:          return int'(a) >= int'(b);
            OP_BLTU:         return a < b;
            OP_BGEU:         return a >= b;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refTarget(input ex_op_e op, input logic [31:0] a,
                                              input logic [31:0] pc, input logic [31:0] imm);
        if (op == OP_JALR) return (a + imm) & ~32'h1;
        return pc + imm;
    endfunction

    // Cycles spent with stall_req high: the accept edge plus every iteration, or one for early-out divides.
    function automatic int refStalls(input ex_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic divide;
        logic signed_div;
        divide     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        signed_div = (op == OP_DIV) || (op == OP_REM);
        if (divide && (b == 32'd0)) return 1;
        if (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 1 + 32;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s check error", tag);
        end
    endtask

    task automatic applyStimulus(input ex_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic use_imm,
                                 input logic [4:0] rd, input logic rd_en);
        ex_valid     = 1'b1;
        ex_op        = op;
        ex_rs1       = rs1;
        ex_rs2       = rs2;
        ex_imm       = imm;
        ex_pc        = pc;
        ex_use_imm   = use_imm;
        ex_rd        = rd;
        ex_rd_enable = rd_en;
        #1;
    endtask

    // Waits out an M op already presented, optionally dropping rdy for drop_len edges.
    task automatic runMop(input string tag, input logic [31:0] expected, input int exp_stalls,
                          input int drop_at, input int drop_len);
        int   edges   = 0;
        logic bubbles = 1'b1;
        while (stall_req === 1'b1 && edges < 200) begin
            if (edges == drop_at) rdy = 1'b0;
            if (edges == drop_at + drop_len) rdy = 1'b1;
            tick();
            edges++;
            if (mem_valid !== 1'b0) bubbles = 1'b0;
        end
        rdy = 1'b1;
        checkOutput({tag, "_stalls"}, 32'(edges), 32'(exp_stalls));
        checkOutput({tag, "_bubble"}, {31'b0, bubbles}, 32'd1);
        tick();
        checkOutput({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
        checkOutput({tag, "_result"}, mem_result, expected);
        ex_valid = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ex_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [31:0] p;
        logic        ui;
        logic        rde;
        logic        br;
        logic [4:0]  rd;

        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        ex_valid = 1'b0;
        ex_op = OP_ADD;
        ex_use_imm = 1'b0;
        ex_pc = '0;
        ex_rs1 = '0;
        ex_rs2 = '0;
        ex_imm = '0;
        ex_rd = '0;
        ex_rd_enable = 1'b0;

        #12;
        checkOutput("rst_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst_result", mem_result, 32'd0);
        checkOutput("rst_rd", {27'b0, mem_rd}, 32'd0);
        checkOutput("rst_rd_en", {31'b0, mem_rd_enable}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall_req}, 32'd0);
        checkOutput("rst_taken", {31'b0, branch_taken}, 32'd0);
        rst = 1'b0;

        applyStimulus(OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'h0, 1'b1, 5'd3, 1'b1);
        checkOutput("addi_stall", {31'b0, stall_req}, 32'd0);
        tick();
        checkOutput("addi_result", mem_result, 32'hFFFF_FFFE);
        checkOutput("addi_valid", {31'b0, mem_valid}, 32'd1);
        checkOutput("addi_rd", {27'b0, mem_rd}, 32'd3);

        applyStimulus(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0, 5'd4, 1'b1);
        checkOutput("blt_taken", {31'b0, branch_taken}, 32'd1);
        checkOutput("blt_target", branch_target, 32'h120);
        tick();
        checkOutput("blt_rd_en", {31'b0, mem_rd_enable}, 32'd0);
        checkOutput("blt_valid", {31'b0, mem_valid}, 32'd1);

        applyStimulus(OP_JAL, 32'd0, 32'd0, 32'h40, 32'h200, 1'b0, 5'd1, 1'b1);
        flush = 1'b1;
        #1;
        checkOutput("flush_jal_taken", {31'b0, branch_taken}, 32'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_jal_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("flush_jal_rd_en", {31'b0, mem_rd_enable}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op  = single_ops[$urandom_range(0, 19)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im  = $urandom;
            p   = $urandom & ~32'h3;
            br  = (op >= OP_BEQ) && (op <= OP_BGEU);
            ui  = (br || op == OP_JAL || op == OP_JALR) ? 1'b0 : 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(1, 31));
            rde = 1'($urandom_range(0, 1));
            applyStimulus(op, a, b, im, p, ui, rd, rde);
            checkOutput($sformatf("rnd%0d_%s_taken", i, op.name()), {31'b0, branch_taken},
                        {31'b0, refTaken(op, a, b)});
            if (refTaken(op, a, b))
                checkOutput($sformatf("rnd%0d_%s_target", i, op.name()), branch_target,
                            refTarget(op, a, p, im));
            tick();
            checkOutput($sformatf("rnd%0d_%s_valid", i, op.name()), {31'b0, mem_valid}, 32'd1);
            checkOutput($sformatf("rnd%0d_%s_rd_en", i, op.name()), {31'b0, mem_rd_enable},
                        {31'b0, rde & ~br});
            if (!br)
                checkOutput($sformatf("rnd%0d_%s_result", i, op.name()), mem_result,
                            refResult(op, a, ui ? im : b, p, im));
        end
        ex_valid = 1'b0;
        #1;

        applyStimulus(OP_MULH, 32'h8000_0000, 32'd2, 32'd0, 32'd0, 1'b0, 5'd5, 1'b1);
        runMop("mulh", 32'hFFFF_FFFF, 33, -1, 0);

        applyStimulus(OP_DIV, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 5'd6, 1'b1);
        runMop("div0", 32'hFFFF_FFFF, 1, -1, 0);

        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 5'd6, 1'b1);
        runMop("rem_ovf", 32'd0, 1, -1, 0);

        for (int i = 0; i < 12; i++) begin
            op = m_ops[$urandom_range(0, 7)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            applyStimulus(op, a, b, 32'd0, 32'd0, 1'b0, 5'd7, 1'b1);
            runMop($sformatf("md%0d_%s", i, op.name()), refResult(op, a, b, 32'd0, 32'd0),
                   refStalls(op, a, b), -1, 0);
        end

        a = $urandom;
        b = $urandom | 32'h1;
        applyStimulus(OP_DIVU, a, b, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1);
        repeat (10) tick();
        flush = 1'b1;
        #1;
        checkOutput("divu_flush_stall", {31'b0, stall_req}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("divu_flush_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("divu_flush_rd_en", {31'b0, mem_rd_enable}, 32'd0);
        runMop("divu_restart", refResult(OP_DIVU, a, b, 32'd0, 32'd0), 33, -1, 0);

        a = $urandom;
        b = $urandom;
        applyStimulus(OP_MUL, a, b, 32'd0, 32'd0, 1'b0, 5'd9, 1'b1);
        runMop("mul_rdy", refResult(OP_MUL, a, b, 32'd0, 32'd0), 33 + 5, 10, 5);

        applyStimulus(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 5'd9, 1'b1);
        tick();
        a = $urandom;
        b = $urandom;
        applyStimulus(OP_MULHU, a, b, 32'd0, 32'd0, 1'b0, 5'd9, 1'b1);
        repeat (5) tick();
        #3;
        rst = 1'b1;
        ex_valid = 1'b0;
        #1;
        checkOutput("rst_busy_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst_busy_result", mem_result, 32'd0);
        checkOutput("rst_busy_rd", {27'b0, mem_rd}, 32'd0);
        checkOutput("rst_busy_rd_en", {31'b0, mem_rd_enable}, 32'd0);
        checkOutput("rst_busy_stall", {31'b0, stall_req}, 32'd0);
        #1;
        rst = 1'b0;
        applyStimulus(OP_MULHU, a, b, 32'd0, 32'd0, 1'b0, 5'd9, 1'b1);
        runMop("mulhu_after_rst", refResult(OP_MULHU, a, b, 32'd0, 32'd0), 33, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32IM pipeline. It consumes the operands, immediate and destination held by the ID/EX pipeline register and computes ALU, branch/jump and multiply/divide results. It registers the result into the EX/MEM boundary. Single-cycle ops complete in one clock. RV32M ops run in an iterative unit that holds the pipeline with a stall request until the result is ready.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `MD_ITER`, 32: iterations per multiply/divide; must equal `XLEN`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rdy`, in, 1: global enable; when low, all state is frozen.
- `flush`, in, 1: kill the current op. Aborts multiply/divide and clears the output valid at the next edge.
- `ex_valid`, in, 1: ID/EX holds a live instruction.
- `ex_op`, in, 6: operation code (package enum).
- `ex_use_imm`, in, 1: operand B is `ex_imm` instead of `ex_rs2`.
- `ex_pc`, in, 32: instruction PC.
- `ex_rs1`, in, 32: register operand A.
- `ex_rs2`, in, 32: register operand B.
- `ex_imm`, in, 32: sign-extended immediate.
- `ex_rd`, in, 5: destination register.
- `ex_rd_enable`, in, 1: instruction writes `ex_rd`.
- `stall_req`, out, 1: combinational; hold the IF/ID/ID-EX registers.
- `branch_taken`, out, 1: combinational redirect request.
- `branch_target`, out, 32: combinational redirect PC.
- `mem_valid`, out, 1: registered EX/MEM valid.
- `mem_result`, out, 32: registered EX/MEM result.
- `mem_rd`, out, 5: registered EX/MEM destination register.
- `mem_rd_enable`, out, 1: registered EX/MEM write enable.

## Operation
- Operand B is `ex_use_imm ? ex_imm : ex_rs2`.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shifts use B[4:0]; all arithmetic wraps modulo 2^32.
- LUI result is the immediate; AUIPC result is `ex_pc + ex_imm`.
- JAL and JALR:
  - Result is `ex_pc + 4`; `branch_taken` is 1.
  - JAL target is `ex_pc + ex_imm`.
  - JALR target is `(ex_rs1 + ex_imm) & ~1`.
- BEQ, BNE, BLT, BGE, BLTU and BGEU compare rs1 with rs2.
  - Taken branches drive target `ex_pc + ex_imm`.
  - `mem_rd_enable` is forced to 0.
- `branch_taken` is gated by `ex_valid & ~flush & ~stall_req`.
- MUL, MULH, MULHSU and MULHU: signed operands are converted to magnitudes, then a 32-step shift-add produces a 64-bit product. The sign is fixed up afterwards. The result is the low or high word as selected by the op.
- DIV, DIVU, REM, REMU: restoring division over 32 steps on magnitudes. Quotient sign is sA^sB; remainder sign is sA.
- Division special cases skip iteration:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
- Multiply/divide FSM:
  - IDLE → BUSY when a valid M op is presented.
  - IDLE → DONE for division special cases.
  - BUSY counts `MD_ITER` cycles, then goes → DONE.
  - DONE → IDLE unconditionally.
- `stall_req` = `ex_valid & is_M(ex_op) & state != DONE & ~flush`.
- Output register: on an enabled edge, `mem_valid` is set to `ex_valid & ~flush & ~stall_req`, and the result, `rd` and `rd_enable` are loaded at the same time. When not valid, `mem_rd_enable` is 0.

## Timing
- Reset values: `mem_valid` 0, `mem_result` 0, `mem_rd` 0, `mem_rd_enable` 0, FSM IDLE, counter 0. `stall_req`, `branch_taken` and `branch_target` follow the (reset) state combinationally.
- Non-M ops have 1-cycle latency: result visible on `mem_*` after the next edge.
- M ops take 34 cycles: the accept edge, 32 BUSY edges, then the DONE edge writes `mem_*`. Special-case divides take 2 cycles.
- A bubble (`mem_valid` = 0) is emitted on every stalled edge.
- Flush during BUSY: FSM → IDLE and `mem_valid` → 0 at the next edge; there is no partial result.
- Flush and a new op in the same cycle: flush wins.
- `rdy` low: nothing changes, including the iteration counter. The FSM resumes where it stopped.
- `rst` is asserted asynchronously and can arrive mid-iteration; it forces every register to its reset value immediately.

## Structure
- Package `ex_pkg` holds:
  - the `ex_op` enum, including the encoding of M ops;
  - the FSM state typedef;
  - the constants `MD_ITER` and `DIV0_QUOT` = 32'hFFFFFFFF.
- Sub-module `muldiv_iter` holds the FSM, counter, 64-bit accumulator and sign fix-up. Its handshake is `start` / `busy` / `done`, plus `result[31:0]`.

## Test plan
- ADDI with rs1 = 5, imm = -7 → after 1 edge `mem_result` = 0xFFFFFFFE, `mem_valid` = 1, `stall_req` never high.
- BLT with rs1 = -1, rs2 = 1, pc = 0x100, imm = 0x20 → `branch_taken` = 1, target 0x120, `mem_rd_enable` = 0.
- MULH with rs1 = 0x80000000, rs2 = 2 → `stall_req` high for 33 cycles, `mem_result` = 0xFFFFFFFF at edge 34.
- DIV with rs1 = 7, rs2 = 0 → `mem_result` = 0xFFFFFFFF after 2 edges; REM with 0x80000000 and -1 → 0.
- DIVU in BUSY cycle 10: pulse `flush` → FSM IDLE and `mem_valid` 0. Then drop `rdy` mid-MUL for 5 cycles → result correct with latency extended by 5.
- Assert `rst` during BUSY → all outputs 0 and `stall_req` 0 immediately.
